// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, FSM encoding and op timing.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_ADD2 = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Number of cycles the ALU inputs must be held for an op. Only divide is multi-cycle;
    // every other code, defined or not, settles in one cycle.
    function automatic logic [CNT_W-1:0] op_cycles(input logic [2:0]       op,
                                                   input logic [CNT_W-1:0] div_cycles);
        if (op == OP_DIV) begin
            return div_cycles;
        end
        return 4'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant. prio names the requester that wins a tie.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    // One-hot grant; a lone requester always wins, a tie goes to prio.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (req0) and the address/branch
// unit (req1). Operands are registered onto the ALU, held for the op's settle time, and
// the result is returned on a valid/ready response channel tagged with the requester id.
module alu_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIV_CYCLES = 4,
    parameter int unsigned OP_W       = 3
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,

    output logic             busy
);

    import alu_pkg::*;

    state_e             state_q;
    logic               prio_q;
    logic               id_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [1:0]         grant;
    logic               grant_id;
    logic [WIDTH-1:0]   grant_a;
    logic [WIDTH-1:0]   grant_b;
    logic [OP_W-1:0]    grant_op;
    logic [CNT_W-1:0]   grant_cnt;
    logic               can_grant;

    rr_arbiter2 u_rr_arbiter2 (
        .valid (({req1_valid, req0_valid})),
        .prio  (prio_q),
        .grant (grant)
    );

    // Grants are offered only in IDLE and never while reset is being applied.
    assign can_grant  = (state_q == IDLE) && reset_n;
    assign req0_ready = can_grant && grant[0];
    assign req1_ready = can_grant && grant[1];
    assign busy       = (state_q != IDLE);

    // Select the winner's request; only meaningful on a grant cycle.
    always_comb begin
        grant_id  = grant[1];
        grant_a   = grant_id ? req1_a  : req0_a;
        grant_b   = grant_id ? req1_b  : req0_b;
        grant_op  = grant_id ? req1_op : req0_op;
        // cnt counts the extra hold cycles beyond the first EXEC cycle.
        grant_cnt = op_cycles(3'(grant_op), 4'(DIV_CYCLES)) - 4'd1;
    end

    // Arbitration FSM with operand, counter and response capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            id_q       <= 1'b0;
            cnt_q      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Without a grant the ALU inputs keep their last values.
                    if (|grant) begin
                        alu_a    <= grant_a;
                        alu_b    <= grant_b;
                        alu_ctrl <= grant_op;
                        id_q     <= grant_id;
                        cnt_q    <= grant_cnt;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_id     <= id_q;
                        rsp_valid  <= 1'b1;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    // The requester just served loses the next tie.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        prio_q    <= ~rsp_id;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters (req0 = execute stage, req1 = address/branch unit).
- Performs round-robin arbitration and registers operands and control onto the ALU inputs.
- Holds the operands stable for the op's settle time: 1 cycle, or DIV_CYCLES cycles for the divide op.
- Returns the captured result, zero flag and requester id on a valid/ready response channel.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU data width.
- DIV_CYCLES, 4, cycles operands are held for op 3'b011 (divide); legal range 1..15.
- OP_W, 3, ALU control width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an op.
- req0_ready  output  1  requester 0 op accepted this cycle.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_op  input  OP_W  requester 0 ALU control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as req0, for requester 1.
- alu_a, alu_b  output  WIDTH  registered ALU sourceA/sourceB.
- alu_ctrl  output  OP_W  registered ALU control.
- alu_result  input  WIDTH  ALU result.
- alu_zero  input  1  ALU zero output, forwarded unmodified.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  requester that issued the op.
- rsp_result  output  WIDTH  captured result.
- rsp_zero  output  1  captured zero flag.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset, asynchronous, while reset_n=0:
  - state=IDLE; prio=0 (req0 preferred).
  - alu_a, alu_b, rsp_result = 0; alu_ctrl=3'b000; rsp_valid=0; rsp_id=0; rsp_zero=0; cnt=0.
  - req*_ready=0; busy=0.
- Reset asserted mid-operation aborts the op. No response is produced, and the op is not replayed after reset.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - reqN_ready is combinational. It is high only for the grant winner, and only in IDLE.
  - Winner rule:
    - Only one valid: that one wins.
    - Both valid: the requester equal to prio wins.
  - On grant (valid && ready):
    - Latch a/b/op into alu_a/alu_b/alu_ctrl; latch id.
    - Load cnt = (op==3'b011) ? DIV_CYCLES-1 : 0.
    - Go to EXEC.
  - No valid: remain in IDLE; alu_* hold their last values.
- EXEC:
  - No ready asserted.
  - cnt!=0: decrement cnt.
  - cnt==0: capture alu_result into rsp_result and alu_zero into rsp_zero; set rsp_id; set rsp_valid=1; go to RESP.
- Latency: grant edge to rsp_valid high.
  - 2 cycles for single-cycle ops.
  - DIV_CYCLES+1 cycles for divide.
- RESP:
  - rsp_* held stable while rsp_valid=1 && rsp_ready=0 (backpressure; no new grant).
  - On rsp_ready=1: clear rsp_valid, set prio = ~rsp_id, go to IDLE.
  - The next grant occurs no earlier than the following cycle, so there is one bubble between ops.
- Undefined op codes (e.g. 3'b101) are passed through with 1-cycle timing; the ALU returns 0.
- Requester inputs are sampled only on the grant cycle. Changes after the grant do not affect the op in flight.
- A valid deasserted before being granted is legal and is simply not serviced.
- Starvation: under continuous contention, grants strictly alternate 0,1,0,1.
- cnt width = 4 bits. Under the legal DIV_CYCLES range cnt never underflows or wraps.

Decomposition:
- Shared package alu_pkg holds:
  - op-code constants: OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_DIV=3'b011, OP_ADD2=3'b100, OP_NOT=3'b110, OP_SLT=3'b111;
  - state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - function op_cycles(op, DIV_CYCLES).
- One natural sub-module: rr_arbiter2, a combinational 2-way round-robin grant from valid[1:0] and prio.
- The FSM, counter and capture registers stay in alu_arbiter.

Test Plan:
- Reset: hold reset_n=0 with req0_valid=1 -> req0_ready=0, rsp_valid=0, alu_ctrl=3'b000, busy=0. Release -> req0 granted on the first edge.
- Single op: req0 a=5, b=3, op=3'b010, rsp_ready=1 -> rsp_valid high 2 cycles after grant, rsp_result=8, rsp_id=0, rsp_zero equals alu_zero for 8.
- Divide timing: req1 a=100, b=7, op=3'b011, DIV_CYCLES=4 -> alu_a/alu_b held 4 cycles, rsp_valid 5 cycles after grant, rsp_result=14, rsp_id=1.
- Contention: both valid continuously for 4 ops, op=3'b001 -> grants in order 0,1,0,1; each rsp_result = a|b of the granted requester.
- Backpressure: rsp_ready=0 for 6 cycles after rsp_valid -> rsp_* stable and no reqN_ready during the stall. Raise rsp_ready -> return to IDLE, next grant goes to the other requester.
- Reset mid-divide: assert reset_n=0 at EXEC cnt=2 -> rsp_valid stays 0 and state=IDLE. After release, the pending req0 is granted with prio=0.
